// File: rtl/mbgd_accum_tree_if.sv
// mbgd_accum_tree_if: beat-in / batch-total-out stream bundle for mbgd_accum_tree.
//   master : producer of beats and consumer of batch totals (testbench, upstream/downstream glue)
//   slave  : the accumulator tree itself
// Signals:
//   in_valid / in_ready / in_last / dot_products : input beat handshake, N packed PW-bit products
//   out_valid / out_ready / out_sum / out_count / out_ovf : one batch total per transaction
// Parameters must match those given to mbgd_accum_tree.
interface mbgd_accum_tree_if #(
  parameter int N         = 8,
  parameter int DW1       = 8,
  parameter int DW2       = 8,
  parameter int BATCH_MAX = 16
);
  localparam int PW = DW1 + DW2;
  localparam int NB = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + NB;
  localparam int BB = $clog2(BATCH_MAX + 1);
  localparam int AW = SW + $clog2(BATCH_MAX);

  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [PW*N-1:0] dot_products;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sum;
  logic [BB-1:0]   out_count;
  logic            out_ovf;

  modport master (
    output in_valid, in_last, dot_products, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_last, dot_products, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mbgd_accum_tree.sv
// mbgd_accum_tree: reduces N packed products per beat through a registered,
// pipelined adder tree, accumulates the per-beat sums over a mini-batch closed
// by in_last and presents one batch total per output transaction.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   clear : synchronous flush of pipeline, accumulator and output register
//   bus   : mbgd_accum_tree_if.slave (input beats, output batch totals)
// Pipeline: input register (edge of acceptance), L add levels, then the
// accumulate/output register, so a one-beat batch appears after L+1 more edges.
module mbgd_accum_tree #(
  parameter int N         = 8,
  parameter int DW1       = 8,
  parameter int DW2       = 8,
  parameter int SIGNED    = 0,
  parameter int BATCH_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  mbgd_accum_tree_if.slave bus
);
  localparam int PW = DW1 + DW2;
  localparam int NB = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + NB;
  localparam int BB = $clog2(BATCH_MAX + 1);
  localparam int AW = SW + $clog2(BATCH_MAX);
  localparam int L  = NB;
  localparam int P  = 32'd1 << NB;

  // Extend one product to tree width according to SIGNED.
  function automatic logic [SW-1:0] ext_term(input logic [PW-1:0] t);
    if (SIGNED != 0) begin
      ext_term = SW'($signed(t));
    end else begin
      ext_term = SW'(t);
    end
  endfunction

  // Extend a tree sum to accumulator width according to SIGNED.
  function automatic logic [AW-1:0] ext_sum(input logic [SW-1:0] s);
    if (SIGNED != 0) begin
      ext_sum = AW'($signed(s));
    end else begin
      ext_sum = AW'(s);
    end
  endfunction

  logic                  stall;
  logic                  accept;

  // Tree is stored heap-style: node i sums children 2i and 2i+1; leaves sit at
  // P..2P-1. Every node is a register, so each tree level is one pipe stage.
  logic [N-1:0][PW-1:0]  leaf;
  logic [P-1:1][SW-1:0]  node;
  logic [2*P-1:2][SW-1:0] nd;
  logic [L:0]            vld;
  logic [L:0]            lst;

  logic [AW-1:0]         acc;
  logic [BB-1:0]         cnt;
  logic                  ovf;
  logic [AW-1:0]         batch_sum;
  logic [BB-1:0]         cnt_next;
  logic [BB:0]           cnt_wide;
  logic                  ovf_next;

  logic                  out_valid;
  logic [AW-1:0]         out_sum;
  logic [BB-1:0]         out_count;
  logic                  out_ovf;

  assign stall         = out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall & ~reset;
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;

  // Tree operand view: extended leaves (zero padding above N) and registered inner nodes.
  always_comb begin
    nd = '0;
    for (int i = 0; i < N; i++) begin
      nd[P + i] = ext_term(leaf[i]);
    end
    for (int i = 2; i < P; i++) begin
      nd[i] = node[i];
    end
  end

  // Next-state terms for the accumulate stage; count saturates, ovf uses the unsaturated count.
  always_comb begin
    batch_sum = acc + ext_sum(node[1]);
    cnt_wide  = {1'b0, cnt} + (BB+1)'(1);
    if (cnt == {BB{1'b1}}) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + BB'(1);
    end
    ovf_next = ovf | (cnt_wide > (BB+1)'(BATCH_MAX));
  end

  // Input register, adder-tree levels and their valid/last tags; all hold on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leaf <= '0;
      node <= '0;
      vld  <= '0;
      lst  <= '0;
    end else if (clear) begin
      leaf <= '0;
      node <= '0;
      vld  <= '0;
      lst  <= '0;
    end else if (!stall) begin
      if (accept) begin
        leaf <= bus.dot_products;
      end
      vld[0] <= accept;
      lst[0] <= accept & bus.in_last;
      for (int s = 1; s <= L; s++) begin
        vld[s] <= vld[s-1];
        lst[s] <= lst[s-1];
      end
      for (int i = 1; i < P; i++) begin
        node[i] <= nd[2*i] + nd[2*i+1];
      end
    end
  end

  // Batch accumulator and output register; a new last result may load in the handshake cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      if (vld[L] && lst[L]) begin
        out_sum   <= batch_sum;
        out_count <= cnt_next;
        out_ovf   <= ovf_next;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        if (vld[L]) begin
          acc <= batch_sum;
          cnt <= cnt_next;
          ovf <= ovf_next;
        end
        if (out_valid && bus.out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
